main_memory: RTL
================

# main_memory

Backing store behind the data cache. It accepts one word request at a time over the cache's start/stop handshake and models a fixed multi-cycle access latency. Reads return the 4-byte word in `mem_data_out`; writes commit `mem_data_in` to the addressed word. It sits directly downstream of the cache and is its only source of miss fills and its only sink for write-through and write-back traffic.

## Interface
- `MEM_WORDS`, 4096: number of 32-bit words; must be a power of two.
- `LATENCY`, 4: cycles from request capture to `interupt_stop`; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `mem_addr` input 32: byte address; bits [1:0] ignored, word index is `mem_addr[log2(MEM_WORDS)+1:2]`.
- `mem_we` input 1: 1 = write request, 0 = read request; sampled only at capture.
- `mem_data_in` input 8 x [0:3]: write data; byte [0] is word bits 7:0, byte [3] is bits 31:24.
- `interupt_start` input 1: request, level; held high by the requester until it sees `interupt_stop`.
- `mem_data_out` output 8 x [0:3]: read data, same byte order as `mem_data_in`.
- `interupt_stop` output 1: one-cycle completion pulse.
- `mem_err` output 1: sticky flag; set when a captured address has nonzero bits above the word index.

## Operation
- Four states: IDLE, BUSY, RESP, RELEASE.
- IDLE, `interupt_start`=1 at an edge:
  - Capture `mem_addr`, `mem_we` and `mem_data_in` into internal registers.
  - Load `cnt` = LATENCY-1 and go to BUSY.
  - Port changes after capture are ignored until the next capture.
- BUSY, `cnt`≠0: decrement `cnt`.
- BUSY, `cnt`=0: go to RESP and set `interupt_stop`<=1.
  - Read: `mem_data_out` <= stored word at the captured index.
  - Write: store the captured data; `mem_data_out` is unchanged.
- RESP, always one cycle:
  - `interupt_stop`<=0.
  - Go to RELEASE if `interupt_start`=1, else IDLE.
- RELEASE: stay until `interupt_start` is sampled 0, then go to IDLE.
  - A new request therefore needs `interupt_start` low for at least one edge after the stop pulse.
- Out-of-range address (upper bits nonzero):
  - Set `mem_err` at capture.
  - A read returns 0; a write is dropped.
  - Handshake timing is unchanged.
- `mem_data_out` holds its last read value indefinitely; writes never alter it.
- Read-after-write to the same word returns the new data.
- Storage is not cleared by reset. It is zero-initialised at time 0 in simulation.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `interupt_stop` 0, `mem_data_out` all bytes 0x00, `mem_err` 0.
  - Captured registers 0.
- Cycle numbering: `interupt_start` sampled high in IDLE at edge E0.
  - `interupt_stop` is high from edge E0+LATENCY to E0+LATENCY+1.
  - The requester samples stop and data at edge E0+LATENCY+1.
- A write commits at edge E0+LATENCY.
- Back-to-back throughput: LATENCY+2 cycles minimum per request (capture, LATENCY-1 BUSY edges, RESP, one low-start edge).
- Reset wins over every edge:
  - Reset asserted at or before edge E0+LATENCY aborts the request. The write is not committed and stop is not pulsed.
  - After reset release, a still-high `interupt_start` is captured as a fresh request.
- `mem_err` clears only on reset.

## Test plan
- Reset, then read word 0x10 with LATENCY=4 → `interupt_stop` is high exactly one cycle after 4 edges from capture, and `mem_data_out` = {00,00,00,00}.
- Write 0x0000_0040 with bytes {DE,AD,BE,EF}, drop start for one cycle, then read 0x40 → `mem_data_out`[0..3] = DE,AD,BE,EF.
- Hold `interupt_start` high for 5 cycles after stop → no second capture and no second stop. Lower it for one cycle, raise it → new request completes LATENCY+1 edges later.
- Change `mem_addr` and `mem_data_in` every cycle during BUSY of a write to 0x80 → only the captured address and data are stored; readback confirms.
- Read 0x0001_0000 with MEM_WORDS=4096 → `mem_err`=1, read data 0, stop timing normal. `mem_err` stays 1 until reset.
- Assert reset at edge E0+2 of a write to 0x44 (prior content 0x11223344) → no stop pulse, and a later read returns 0x11223344.

Source files
------------

// File: rtl/main_memory_if.sv
// Request/response bundle between the data cache (master) and main_memory (slave).
// Data bytes are indexed [0:3]; byte [0] carries word bits 7:0.
interface main_memory_if;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_data_in  [0:3];
  logic        interupt_start;
  logic [7:0]  mem_data_out [0:3];
  logic        interupt_stop;
  logic        mem_err;

  modport master (
    output mem_addr, mem_we, mem_data_in, interupt_start,
    input  mem_data_out, interupt_stop, mem_err
  );

  modport slave (
    input  mem_addr, mem_we, mem_data_in, interupt_start,
    output mem_data_out, interupt_stop, mem_err
  );
endinterface

// File: rtl/main_memory.sv
// Word-addressed backing store with a fixed access latency and a level-start /
// pulse-stop handshake. Out-of-range addresses set a sticky error flag.
module main_memory #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 4
) (
  input  logic         clk,
  input  logic         reset,
  main_memory_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        stop_q, stop_d;
  logic        err_q, err_d;

  // Storage is deliberately outside reset; zero at time 0 only.
  logic [31:0] mem [MEM_WORDS] = '{default: '0};

  logic [31:0]      wdata_in;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             addr_oob_in;
  logic             done;
  logic             mem_wr;

  always_comb begin
    wdata_in = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wdata_in[8*i +: 8] = bus.mem_data_in[i];
    end
  end

  assign idx         = addr_q[IDX_W+1:2];
  assign in_range    = (addr_q >> (IDX_W + 2)) == '0;
  assign addr_oob_in = (bus.mem_addr >> (IDX_W + 2)) != '0;
  assign done        = (state_q == BUSY) && (cnt_q == '0);
  // Reset on the commit edge aborts the write, hence the gate on reset.
  assign mem_wr      = done && we_q && in_range && !reset;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stop_d  = stop_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.interupt_start) begin
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wdata_d = wdata_in;
          cnt_d   = 8'(LATENCY - 1);
          err_d   = err_q | addr_oob_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = RESP;
          stop_d  = 1'b1;
          if (!we_q) begin
            rdata_d = in_range ? mem[idx] : '0;
          end
        end
      end
      RESP: begin
        stop_d  = 1'b0;
        state_d = bus.interupt_start ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!bus.interupt_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      bus.mem_data_out[i] = rdata_q[8*i +: 8];
    end
  end

  assign bus.interupt_stop = stop_q;
  assign bus.mem_err       = err_q;
endmodule
